tanh_cordic: RTL and testbench

TANH_CORDIC -- requirements
Module: tanh_cordic

---
 rtl/tanh_cordic_pkg.sv | 36 +++
 rtl/tanh_cordic_div.sv | 74 +++++++
 rtl/tanh_cordic.sv | 157 +++++++++++++++
 tb/tb_tanh_cordic.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tanh_cordic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tanh_cordic_pkg : shared widths, CORDIC tables and FSM encoding for tanh_cordic
// Rev 1.0
// ---------------------------------------------------------------------------
package tanh_cordic_pkg;

  localparam int W_IO      = 9;
  localparam int W_DP      = 20;
  localparam int XY_FRAC   = 15;
  localparam int ANG_SCALE = 402;
  localparam int ROT_STEPS = 16;
  localparam int DIV_BITS  = 8;
  localparam int STEP_W    = 4;

  // Q4.16 rotation angles per step; step 0 is atanh(0.75), then atanh(2^-shift)
  localparam int ATANH_TAB [ROT_STEPS] = '{
    63764, 35999, 16739, 8235, 4101, 4101, 2049, 1024,
    512,   256,   128,   64,   32,   16,   8,    8
  };

  // Step 0 uses shift 2 inside the expanded (v - v>>>2) term
  localparam int SHIFT_TAB [ROT_STEPS] = '{
    2, 1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13
  };

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ROT  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tanh_cordic_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tanh_cordic_div : restoring divider, one quotient bit per cycle, MSB first
// Rev 1.0
// ---------------------------------------------------------------------------
module tanh_cordic_div #(
  parameter int W  = 20,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_i,
  input  logic [W-1:0]  num_i,
  input  logic [W-1:0]  den_i,
  output logic          done_o,
  output logic [QW-1:0] quo_o
);

  localparam int CW = $clog2(QW + 1);

  logic [W:0]    rem_q, rem_d, rem_src, rem_shl, den_ext;
  logic [W-1:0]  den_q, den_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          bit_set;

  // The start cycle already resolves the MSB, so the quotient takes exactly QW cycles
  always_comb begin
    rem_src = start_i ? {1'b0, num_i} : rem_q;
    den_ext = start_i ? {1'b0, den_i} : {1'b0, den_q};
    rem_shl = rem_src << 1;
    bit_set = (rem_shl >= den_ext);
    rem_d   = rem_q;
    den_d   = den_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start_i) begin
      rem_d = bit_set ? (rem_shl - den_ext) : rem_shl;
      den_d = den_i;
      quo_d = QW'(bit_set);
      cnt_d = CW'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = bit_set ? (rem_shl - den_ext) : rem_shl;
      quo_d = {quo_q[QW-2:0], bit_set};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(QW - 1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // High during the cycle whose closing edge writes the last quotient bit
  assign done_o = run_q && (cnt_q == CW'(QW - 1));
  assign quo_o  = quo_q;

endmodule
`default_nettype wire

// File: rtl/tanh_cordic.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tanh_cordic : hyperbolic CORDIC rotation followed by y/x division -> tanh(a)
// Rev 1.0
// ---------------------------------------------------------------------------
module tanh_cordic
  import tanh_cordic_pkg::*;
#(
  parameter int W_IO = tanh_cordic_pkg::W_IO,
  parameter int W_DP = tanh_cordic_pkg::W_DP
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   trig,
  input  logic signed [W_IO-1:0] a,
  output logic                   busy,
  output logic                   vld,
  output logic signed [W_IO-1:0] tanha_latch
);

  localparam logic signed [W_DP-1:0] X_ONE   = W_DP'(1) << XY_FRAC;
  localparam logic signed [W_DP-1:0] ANG_MUL = W_DP'(ANG_SCALE);

  state_t                   state_q, state_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic signed [W_DP-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [W_IO-1:0]   a_q, a_d, latch_q, latch_d;
  logic                     div_start_q, div_start_d, vld_q, vld_d;

  logic [STEP_W-1:0]        shift;
  logic signed [W_DP-1:0]   x_sh, y_sh, dx, dy, ang, a_ext, z_load;
  logic signed [W_DP-1:0]   x_rot, y_rot, z_rot;
  logic [W_DP-1:0]          y_abs;
  logic [DIV_BITS-1:0]      quo;
  logic [W_IO-1:0]          quo_ext;
  logic                     div_done;

  assign a_ext   = {{(W_DP-W_IO){a_q[W_IO-1]}}, a_q};
  assign z_load  = a_ext * ANG_MUL;
  assign y_abs   = y_q[W_DP-1] ? -y_q : y_q;
  assign quo_ext = W_IO'(quo);

  // One rotation; x and y both use the pre-step values, sigma = +1 when z >= 0
  always_comb begin
    shift = STEP_W'(SHIFT_TAB[step_q]);
    ang   = W_DP'(ATANH_TAB[step_q]);
    x_sh  = x_q >>> shift;
    y_sh  = y_q >>> shift;
    if (step_q == '0) begin
      dx = y_q - y_sh;
      dy = x_q - x_sh;
    end else begin
      dx = y_sh;
      dy = x_sh;
    end
    if (!z_q[W_DP-1]) begin
      x_rot = x_q + dx;
      y_rot = y_q + dy;
      z_rot = z_q - ang;
    end else begin
      x_rot = x_q - dx;
      y_rot = y_q - dy;
      z_rot = z_q + ang;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    a_d         = a_q;
    latch_d     = latch_q;
    div_start_d = 1'b0;
    vld_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          a_d     = a;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        x_d     = X_ONE;
        y_d     = '0;
        z_d     = z_load;
        step_d  = '0;
        state_d = S_ROT;
      end
      S_ROT: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(ROT_STEPS - 1)) begin
          step_d      = '0;
          div_start_d = 1'b1;
          state_d     = S_DIV;
        end
      end
      S_DIV: begin
        if (div_done) state_d = S_DONE;
      end
      S_DONE: begin
        latch_d = y_q[W_DP-1] ? -quo_ext : quo_ext;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      a_q         <= '0;
      latch_q     <= '0;
      div_start_q <= 1'b0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      a_q         <= a_d;
      latch_q     <= latch_d;
      div_start_q <= div_start_d;
      vld_q       <= vld_d;
    end
  end

  // x is always positive after rotation, so it feeds the divisor directly
  tanh_cordic_div #(
    .W  (W_DP),
    .QW (DIV_BITS)
  ) u_div (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (div_start_q),
    .num_i   (y_abs),
    .den_i   (x_q),
    .done_o  (div_done),
    .quo_o   (quo)
  );

  assign busy        = (state_q != S_IDLE);
  assign vld         = vld_q;
  assign tanha_latch = latch_q;

endmodule
`default_nettype wire

// File: tb/tb_tanh_cordic.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tanh_cordic : directed self-checking bench for tanh_cordic
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tanh_cordic;

  localparam int W_IO = 9;
  localparam int W_DP = 20;
  localparam real PI  = 3.14159265358979;

  logic                   clk  = 1'b0;
  logic                   rstn = 1'b0;
  logic                   trig = 1'b0;
  logic signed [W_IO-1:0] a    = '0;
  logic                   busy, vld;
  logic signed [W_IO-1:0] tanha_latch;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tanh_cordic #(
    .W_IO (W_IO),
    .W_DP (W_DP)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .trig        (trig),
    .a           (a),
    .busy        (busy),
    .vld         (vld),
    .tanha_latch (tanha_latch)
  );

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    int d;
    n_tests++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_calc(input logic signed [W_IO-1:0] av);
    a    = av;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_vld(output int lat, output int res);
    lat = -1;
    res = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (vld) begin
        lat = c;
        res = int'(tanha_latch);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, res, vcnt, first_v, second_v, expv;
    real t;

    repeat (3) tick();
    check_val("rst_busy", int'(busy), 0, 0);
    check_val("rst_vld", int'(vld), 0, 0);
    check_val("rst_latch", int'(tanha_latch), 0, 0);
    rstn = 1'b1;
    tick();

    start_calc(9'sd0);
    check_val("busy_after_trig", int'(busy), 1, 0);
    wait_vld(lat, res);
    check_val("latency_a0", lat, 26, 0);
    check_val("tanh_a0", res, 0, 0);
    check_val("busy_at_vld", int'(busy), 0, 0);
    tick();
    check_val("vld_one_cycle", int'(vld), 0, 0);

    // tanh(pi/4)*256 = 167.9
    start_calc(9'sd128);
    wait_vld(lat, res);
    check_val("tanh_a128", res, 167, 1);
    // tanh(-pi/2)*256 = -234.8
    start_calc(-9'sd256);
    wait_vld(lat, res);
    check_val("tanh_a-256", res, -234, 1);
    // tanh(1.5647)*256 = 234.5
    start_calc(9'sd255);
    wait_vld(lat, res);
    check_val("tanh_a255", res, 234, 1);
    repeat (5) tick();
    check_val("latch_held", int'(tanha_latch), 234, 1);

    // trig held: first result at 26, DONE-cycle trig ignored, restart at 27 -> 53
    a = 9'sd128;
    trig = 1'b1;
    tick();
    vcnt = 0; first_v = -1; second_v = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 40) trig = 1'b0;
      if (c == 26) check_val("held_busy_at_vld", int'(busy), 0, 0);
      if (c == 27) check_val("held_restart_busy", int'(busy), 1, 0);
      if (vld) begin
        if (c <= 40) vcnt++;
        if (first_v < 0) first_v = c;
        else if (second_v < 0) second_v = c;
      end
    end
    check_val("held_vld_count", vcnt, 1, 0);
    check_val("held_first_vld", first_v, 26, 0);
    check_val("held_second_vld", second_v, 53, 0);

    // reset at cycle 10 of a computation
    start_calc(9'sd128);
    repeat (9) tick();
    rstn = 1'b0;
    tick();
    check_val("abort_busy", int'(busy), 0, 0);
    check_val("abort_vld", int'(vld), 0, 0);
    check_val("abort_latch", int'(tanha_latch), 0, 0);
    tick();
    rstn = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (vld) vcnt++;
    end
    check_val("abort_no_vld", vcnt, 0, 0);
    // tanh(pi/8)*256 = 95.66
    start_calc(9'sd64);
    wait_vld(lat, res);
    check_val("latency_after_abort", lat, 26, 0);
    check_val("tanh_a64", res, 95, 1);

    for (int av = -256; av <= 255; av++) begin
      start_calc(W_IO'(av));
      wait_vld(lat, res);
      t    = $tanh(real'(av) * 2.0 * PI / 1024.0) * 256.0;
      expv = $rtoi(t);
      check_val($sformatf("sweep_a%0d", av), res, expv, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
